// File: rtl/add_operand_sequencer.sv
// add_operand_sequencer
// Sequencer for the 8-bit ripple adder (adder8). It takes a 3-beat byte
// transaction (ctrl, A, B), drives the adder operands from registers, captures
// the sum with C/Z/N/V flags, and holds the result until it is consumed.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   in_data/in_valid    input byte stream (ctrl, A, B)
//   in_ready            beat accepted when in_valid && in_ready
//   add_a/add_b/add_cin registered operands driven to adder8
//   add_sum/add_cout    adder8 result
//   res_data/res_flags  captured sum and {C, Z, N, V}
//   res_valid/res_ready result handshake
//   timeout_err         one-cycle pulse when a stalled transaction is aborted
//
// State  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a ctrl beat
// GET_A  | waiting for operand A (stall timer running)
// GET_B  | waiting for operand B (stall timer running)
// EXEC   | adder inputs stable; capture sum/flags at the end of the cycle
// HOLD   | result held on res_* until res_ready
module add_operand_sequencer #(
  parameter int unsigned IDLE_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] add_a,
  output logic [7:0] add_b,
  output logic       add_cin,
  input  logic [7:0] add_sum,
  input  logic       add_cout,
  output logic [7:0] res_data,
  output logic [3:0] res_flags,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       timeout_err
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_GET_A = 3'd1;
  localparam logic [2:0] ST_GET_B = 3'd2;
  localparam logic [2:0] ST_EXEC  = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

  // The stall timer counts down the remaining in_valid-low cycles; an
  // abort fires on a low cycle seen with the count already at zero.
  localparam logic [7:0] CNT_LOAD = 8'(IDLE_TIMEOUT - 1);

  logic [2:0] state;
  logic [7:0] op_a;
  logic       sub_q;
  logic       chain_q;
  logic       c_store;
  logic [7:0] idle_cnt;
  logic       beat;
  logic       in_getop;
  logic       ovf;

  assign in_ready  = (state == ST_IDLE) || (state == ST_GET_A) || (state == ST_GET_B);
  assign res_valid = (state == ST_HOLD);
  assign beat      = in_valid && in_ready;
  assign in_getop  = (state == ST_GET_A) || (state == ST_GET_B);

  // Signed overflow is judged on the operands actually presented to the
  // adder, so SUB sees the inverted B.
  assign ovf = (add_a[7] == add_b[7]) && (add_sum[7] != add_a[7]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      op_a        <= 8'd0;
      sub_q       <= 1'b0;
      chain_q     <= 1'b0;
      add_a       <= 8'd0;
      add_b       <= 8'd0;
      add_cin     <= 1'b0;
      res_data    <= 8'd0;
      res_flags   <= 4'd0;
      c_store     <= 1'b0;
      timeout_err <= 1'b0;
      idle_cnt    <= 8'd0;
    end else begin
      timeout_err <= 1'b0;
      if (in_getop && !beat) begin
        if (idle_cnt == 8'd0) begin
          state       <= ST_IDLE;
          timeout_err <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt - 8'd1;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (beat) begin
              sub_q    <= in_data[0];
              chain_q  <= in_data[1];
              idle_cnt <= CNT_LOAD;
              state    <= ST_GET_A;
            end
          end
          ST_GET_A: begin
            op_a     <= in_data;
            idle_cnt <= CNT_LOAD;
            state    <= ST_GET_B;
          end
          ST_GET_B: begin
            add_a    <= op_a;
            add_b    <= sub_q ? ~in_data : in_data;
            add_cin  <= chain_q ? c_store : sub_q;
            idle_cnt <= 8'd0;
            state    <= ST_EXEC;
          end
          ST_EXEC: begin
            res_data  <= add_sum;
            res_flags <= {add_cout, (add_sum == 8'd0), add_sum[7], ovf};
            c_store   <= add_cout;
            state     <= ST_HOLD;
          end
          ST_HOLD: begin
            if (res_ready) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
